// File: rtl/dm_demux_pkg.sv
// rtl/dm_demux_pkg.sv - shared constants and types for the 1-to-4 demux latch
package dm_demux_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_SEQ  = 1'b1;

  // Pointer value at which a sequential frame is complete
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CH_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/dm_demux_seq.sv
// rtl/dm_demux_seq.sv - sequential write pointer and frame FSM
module dm_demux_seq
  import dm_demux_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic             i_mode,
  output logic [SEL_W-1:0] o_tgt,
  output logic [SEL_W-1:0] o_ptr,
  output logic             o_frame
);

  seq_state_t       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic             r_frame;
  logic             r_mode_q;
  logic             w_mode_chg;

  // A mode switch restarts the sequence, so a write in that cycle lands on channel 0
  assign w_mode_chg = (i_mode != r_mode_q);
  assign o_tgt      = w_mode_chg ? '0 : r_ptr;
  assign o_ptr      = r_ptr;
  assign o_frame    = r_frame;

  // Pointer counter, frame FSM and one-cycle frame pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_frame  <= 1'b0;
      r_mode_q <= MODE_ADDR;
    end else begin
      r_mode_q <= i_mode;
      r_frame  <= 1'b0;
      if (w_mode_chg) begin
        if (i_mode == MODE_SEQ && i_wr) begin
          r_ptr   <= SEL_W'(1);
          r_state <= FILL;
        end else begin
          r_ptr   <= '0;
          r_state <= IDLE;
        end
      end else if (i_mode == MODE_SEQ) begin
        if (i_wr) begin
          if (r_ptr == PTR_LAST) begin
            r_ptr   <= '0;
            r_state <= DONE;
            r_frame <= 1'b1;
          end else begin
            r_ptr   <= r_ptr + SEL_W'(1);
            r_state <= FILL;
          end
        end else if (r_state == DONE) begin
          r_state <= IDLE;
        end
      end
    end
  end

endmodule

// File: rtl/dm_demux_latch.sv
// rtl/dm_demux_latch.sv - 1-to-4 addressable demux latch; DM_DEMUX_PARITY_EN enables PAR
module dm_demux_latch
  import dm_demux_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_g,
  input  logic              i_a,
  input  logic              i_b,
  input  logic              i_d,
  input  logic              i_mode,
  input  logic              i_clr,
  output logic [CH_NUM-1:0] o_y,
  output logic [SEL_W-1:0]  o_ptr,
  output logic              o_frame,
  output logic              o_par
);

  logic [CH_NUM-1:0] r_y;
  logic [CH_NUM-1:0] w_y_nxt;
  logic [SEL_W-1:0]  w_seq_tgt;
  logic [SEL_W-1:0]  w_tgt;
  logic              w_wr;

  assign w_wr = ~i_g;

  dm_demux_seq u_seq (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (w_wr),
    .i_mode  (i_mode),
    .o_tgt   (w_seq_tgt),
    .o_ptr   (o_ptr),
    .o_frame (o_frame)
  );

  assign w_tgt = (i_mode == MODE_SEQ) ? w_seq_tgt : {i_b, i_a};

  // Next latch contents: clear wipes the other channels, a strobe updates the target
  always_comb begin
    w_y_nxt = r_y;
    if (i_clr) begin
      w_y_nxt = '0;
      if (w_wr) w_y_nxt[w_tgt] = i_d;
    end else if (w_wr) begin
      w_y_nxt[w_tgt] = i_d;
    end
  end

  // Latch array register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_y <= '0;
    else       r_y <= w_y_nxt;
  end

  assign o_y = r_y;

`ifdef DM_DEMUX_PARITY_EN
  logic r_par;

  // Parity tracks the value being loaded so it lines up with Y
  always_ff @(posedge i_clk) begin
    if (i_rst) r_par <= 1'b0;
    else       r_par <= ^w_y_nxt;
  end

  assign o_par = r_par;
`else
  assign o_par = 1'b0;
`endif

endmodule

// File: tb/tb_dm_demux_latch.sv
// tb/tb_dm_demux_latch.sv - directed self-checking bench for dm_demux_latch
module tb_dm_demux_latch;

  logic       clk = 1'b0;
  logic       rst, g, a, b, d, mode, clr;
  logic [3:0] y;
  logic [1:0] ptr;
  logic       frame, par;
  int         errors = 0;
  int         checks = 0;

  dm_demux_latch dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_g     (g),
    .i_a     (a),
    .i_b     (b),
    .i_d     (d),
    .i_mode  (mode),
    .i_clr   (clr),
    .o_y     (y),
    .o_ptr   (ptr),
    .o_frame (frame),
    .o_par   (par)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_write(input logic [1:0] adr, input logic dv, input logic cl);
    mode = 1'b0; g = 1'b0; {b, a} = adr; d = dv; clr = cl;
    tick();
    g = 1'b1; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; g = 1'b0; a = 1'b1; b = 1'b0; d = 1'b1; mode = 1'b1; clr = 1'b0;
    tick();
    tick();
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL reset_y got=%b exp=0000", y); end
    checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr got=%0d exp=0", ptr); end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", frame); end
    checks++; if (par !== 1'b0) begin errors++; $display("FAIL reset_par got=%b exp=0", par); end
    rst = 1'b0; g = 1'b1; mode = 1'b0; d = 1'b0;
    tick();
  endtask

  task automatic test_addressed();
    addr_write(2'd2, 1'b1, 1'b0);
    checks++; if (y !== 4'b0100) begin errors++; $display("FAIL addr_write_y got=%b exp=0100", y); end
    d = 1'b0; g = 1'b1;
    tick();
    checks++; if (y !== 4'b0100) begin errors++; $display("FAIL addr_hold_y got=%b exp=0100", y); end
    checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL addr_hold_ptr got=%0d exp=0", ptr); end
  endtask

  task automatic test_sequential();
    logic [3:0] dseq;
    logic [1:0] pexp [4];
    dseq = 4'b1101;
    pexp[0] = 2'd1; pexp[1] = 2'd2; pexp[2] = 2'd3; pexp[3] = 2'd0;
    mode = 1'b1; g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = dseq[i];
      tick();
      checks++; if (ptr !== pexp[i]) begin errors++; $display("FAIL seq_ptr[%0d] got=%0d exp=%0d", i, ptr, pexp[i]); end
      checks++; if (frame !== (i == 3)) begin errors++; $display("FAIL seq_frame[%0d] got=%b exp=%b", i, frame, (i == 3)); end
    end
    checks++; if (y !== 4'b1101) begin errors++; $display("FAIL seq_y got=%b exp=1101", y); end
    g = 1'b1;
    tick();
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL seq_frame_drop got=%b exp=0", frame); end
    checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL seq_ptr_hold got=%0d exp=0", ptr); end
  endtask

  task automatic test_back_to_back();
    int nframes;
    nframes = 0;
    mode = 1'b1; g = 1'b0; d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (frame === 1'b1) nframes++;
      checks++; if (frame !== ((i % 4) == 3)) begin errors++; $display("FAIL b2b_frame[%0d] got=%b exp=%b", i, frame, ((i % 4) == 3)); end
    end
    checks++; if (nframes != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", nframes); end
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL b2b_y got=%b exp=0000", y); end
    g = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) addr_write(2'(i), 1'b1, 1'b0);
    checks++; if (y !== 4'b1111) begin errors++; $display("FAIL clr_setup got=%b exp=1111", y); end
    g = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL clr_plain got=%b exp=0000", y); end
    for (int i = 0; i < 4; i++) addr_write(2'(i), 1'b1, 1'b0);
    addr_write(2'd1, 1'b1, 1'b1);
    checks++; if (y !== 4'b0010) begin errors++; $display("FAIL clr_demux got=%b exp=0010", y); end
    checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL clr_ptr got=%0d exp=0", ptr); end
  endtask

  task automatic test_midframe();
    mode = 1'b1; g = 1'b0; d = 1'b1;
    tick();
    tick();
    checks++; if (ptr !== 2'd2) begin errors++; $display("FAIL mid_ptr_pre got=%0d exp=2", ptr); end
    mode = 1'b0; g = 1'b1;
    tick();
    checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL mid_toggle_ptr got=%0d exp=0", ptr); end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL mid_toggle_frame got=%b exp=0", frame); end
    mode = 1'b1; g = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL mid_rst_y got=%b exp=0000", y); end
    checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL mid_rst_ptr got=%0d exp=0", ptr); end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL mid_rst_frame got=%b exp=0", frame); end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (frame !== 1'b0) begin errors++; $display("FAIL mid_post_frame[%0d] got=%b exp=0", i, frame); end
    end
    checks++; if (ptr !== 2'd2) begin errors++; $display("FAIL mid_post_ptr got=%0d exp=2", ptr); end
    g = 1'b1;
    tick();
  endtask

  task automatic test_parity();
    logic exp_odd;
`ifdef DM_DEMUX_PARITY_EN
    exp_odd = 1'b1;
`else
    exp_odd = 1'b0;
`endif
    addr_write(2'd0, 1'b1, 1'b1);
    addr_write(2'd1, 1'b1, 1'b0);
    addr_write(2'd2, 1'b1, 1'b0);
    checks++; if (y !== 4'b0111) begin errors++; $display("FAIL par_y0111 got=%b exp=0111", y); end
    checks++; if (par !== exp_odd) begin errors++; $display("FAIL par_0111 got=%b exp=%b", par, exp_odd); end
    addr_write(2'd0, 1'b0, 1'b0);
    checks++; if (y !== 4'b0110) begin errors++; $display("FAIL par_y0110 got=%b exp=0110", y); end
    checks++; if (par !== 1'b0) begin errors++; $display("FAIL par_0110 got=%b exp=0", par); end
  endtask

  initial begin
    test_reset();
    test_addressed();
    test_sequential();
    test_back_to_back();
    test_clear();
    test_midframe();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
